test_fifo: RTL and testbench



---
 rtl/test_fifo_pkg.sv | 12 +
 rtl/test_fifo_if.sv | 24 ++
 rtl/test_fifo_packer.sv | 36 +++
 rtl/test_fifo.sv | 103 ++++++++++
 tb/tb_test_fifo.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/test_fifo_pkg.sv
// Shared widths and types for the 16-to-128-bit clock-segment FIFO.
package test_fifo_pkg;

    localparam int WR_W  = 16;
    localparam int RD_W  = 128;
    localparam int RATIO = RD_W / WR_W;
    localparam int CNT_W = $clog2(RATIO);

    typedef logic [WR_W-1:0] halfword_t;
    typedef logic [RD_W-1:0] word_t;

endpackage

// File: rtl/test_fifo_if.sv
// Host-pipe write / segment-record read bundle of test_fifo.
interface test_fifo_if;
    import test_fifo_pkg::*;

    halfword_t din;
    logic      wr_en;
    logic      rd_en;
    word_t     dout;
    logic      empty;
    logic      full;
    logic      overflow;
    logic      underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, empty, full, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, empty, full, overflow, underflow
    );

endinterface

// File: rtl/test_fifo_packer.sv
// Assembles eight accepted halfwords into one 128-bit word; the first halfword ends up in the top bits.
module test_fifo_packer
    import test_fifo_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_accept,
    input  halfword_t din,
    output word_t     word,
    output logic      commit
);

    logic [CNT_W-1:0]     hw_cnt;
    logic [RD_W-WR_W-1:0] shreg;

    // The eighth halfword is not registered here; it joins the word on its way into storage.
    assign commit = wr_accept && (hw_cnt == CNT_W'(RATIO - 1));
    assign word   = {shreg, din};

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_cnt <= '0;
            shreg  <= '0;
        end else if (wr_accept) begin
            if (commit) begin
                hw_cnt <= '0;
                shreg  <= '0;
            end else begin
                hw_cnt <= hw_cnt + CNT_W'(1);
                shreg  <= {shreg[RD_W-2*WR_W-1:0], din};
            end
        end
    end

endmodule

// File: rtl/test_fifo.sv
// First-word-fall-through FIFO of 128-bit clock-segment records fed by 16-bit host halfwords.
// Define TEST_FIFO_ERR_FLAGS_EN to drive overflow/underflow; otherwise both are tied to 0.
module test_fifo
    import test_fifo_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input logic       clk,
    input logic       rst,
    test_fifo_if.slave bus
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          empty_q;
    logic          full_q;
    logic          wr_accept;
    logic          rd_accept;
    logic          commit;
    word_t         pack_word;

    assign wr_accept = bus.wr_en && !full_q;
    assign rd_accept = bus.rd_en && !empty_q;

    test_fifo_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .wr_accept (wr_accept),
        .din       (bus.din),
        .word      (pack_word),
        .commit    (commit)
    );

    // NOTE: storage has no reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr] <= pack_word;
        end
    end

    // NOTE: default assignment first so no path leaves count_nxt unassigned (no latch).
    always_comb begin
        count_nxt = count;
        unique case ({commit, rd_accept})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == DEPTH_C);
        end
    end

    assign bus.dout  = empty_q ? '0 : mem[rd_ptr];
    assign bus.empty = empty_q;
    assign bus.full  = full_q;

`ifdef TEST_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.wr_en && full_q;
            underflow_q <= bus.rd_en && empty_q;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_test_fifo.sv
// Self-checking bench for test_fifo (DEPTH=4) against a queue-based reference model.
module tb_test_fifo;
    import test_fifo_pkg::*;

    localparam int DEPTH = 4;
`ifdef TEST_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam word_t FIRST_WORD = 128'h0001_0002_0003_0004_0005_0006_0007_0008;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    test_fifo_if bus ();

    test_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int        checks   = 0;
    int        failures = 0;
    word_t     model_q [$];
    halfword_t part [$];
    bit        exp_ov;
    bit        exp_un;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The first halfword of a word occupies bits [127:112], the k-th one [127-16k -: 16].
    function automatic word_t assemble();
        word_t w = '0;
        for (int k = 0; k < RATIO; k++) begin
            w[RD_W-1-WR_W*k -: WR_W] = part[k];
        end
        return w;
    endfunction

    task automatic cycle(input bit r, input bit wr, input halfword_t d, input bit rd);
        bit m_full;
        bit m_empty;
        rst       = r;
        bus.wr_en = wr;
        bus.din   = d;
        bus.rd_en = rd;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        if (!r && rd && !m_empty) begin
            check("pop_sample", bus.dout, model_q[0]);
        end
        if (r) begin
            model_q.delete();
            part.delete();
            exp_ov = 1'b0;
            exp_un = 1'b0;
        end else begin
            exp_ov = wr && m_full;
            exp_un = rd && m_empty;
            if (rd && !m_empty) begin
                void'(model_q.pop_front());
            end
            if (wr && !m_full) begin
                part.push_back(d);
                if (part.size() == RATIO) begin
                    model_q.push_back(assemble());
                    part.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("empty", bus.empty, model_q.size() == 0);
        check("full", bus.full, model_q.size() == DEPTH);
        check("dout", bus.dout, (model_q.size() != 0) ? model_q[0] : '0);
        check("overflow", bus.overflow, exp_ov && ERR_EN);
        check("underflow", bus.underflow, exp_un && ERR_EN);
    endtask

    task automatic write_rand(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, halfword_t'($urandom), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        halfword_t h0;
        bus.din   = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;

        // Reset state
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("reset_empty", bus.empty, 1'b1);
        check("reset_dout", bus.dout, '0);

        // First word 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, halfword_t'(i), 1'b0);
            if (i < 8) check("empty_partial", bus.empty, 1'b1);
        end
        check("first_word", bus.dout, FIRST_WORD);

        // FWFT pop with two stored words
        write_rand(8);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("drained_empty", bus.empty, 1'b1);

        // Fill to DEPTH, reject one write, drain in order
        write_rand(RATIO * DEPTH);
        check("full_after_fill", bus.full, 1'b1);
        cycle(1'b0, 1'b1, 16'hdead, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Underflow for two cycles, then idle
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Pop in the same cycle as a committing write
        write_rand(8 + 7);
        cycle(1'b0, 1'b1, halfword_t'($urandom), 1'b1);
        check("simul_not_full", bus.full, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("simul_one_word", bus.empty, 1'b1);

        // Reset with 2 words + 5 halfwords pending
        write_rand(2 * 8 + 5);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("midrst_empty", bus.empty, 1'b1);
        check("midrst_full", bus.full, 1'b0);
        h0 = halfword_t'($urandom);
        cycle(1'b0, 1'b1, h0, 1'b0);
        write_rand(7);
        check("midrst_head", bus.dout[127:112], h0);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic alternating fill-heavy and drain-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 120; i++) begin
                bit wr;
                bit rd;
                wr = (ph % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
                rd = (ph % 2 == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
                cycle(1'b0, wr, halfword_t'($urandom), rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
